// File: rtl/spi_trace_rx_if.sv
// Output stream of the trace receiver: FIFO head word with a valid/ready handshake.
interface spi_trace_rx_if #(parameter int W = 32);
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/spi_trace_rx.sv
// SPI-style debug trace receiver: oversampled serial input, word assembly,
// and a small FIFO with a registered head word and sticky error flags.
module spi_trace_rx #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   spi_sck,
    input  logic                   spi_cs,
    input  logic                   spi_mosi,
    spi_trace_rx_if.master         out_if,
    output logic                   overflow,
    output logic                   frame_err,
    input  logic                   clear_err,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_t;

    logic [2:0]    sck_q;
    logic [1:0]    cs_q;
    logic [1:0]    mosi_q;
    logic [1:0]    warm;
    logic          cs_prev;
    logic          cs_s;
    logic          sample;
    logic          cs_fall;

    state_t        state, state_nx;
    logic          push, shift_en, cnt_clr, ferr_set;
    logic [W-1:0]  shreg;
    logic [CW-1:0] cnt;
    logic          last_bit;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr, rptr_nx;
    logic [LW-1:0] count, count_left;
    logic          pop, full, wr, drop;

    // cs_prev only follows the pin once the synchronizer holds real samples, so a
    // cs already low at reset release is not mistaken for a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q   <= '0;
            cs_q    <= '1;
            mosi_q  <= '0;
            warm    <= '0;
            cs_prev <= 1'b0;
        end else begin
            sck_q   <= {sck_q[1:0], spi_sck};
            cs_q    <= {cs_q[0], spi_cs};
            mosi_q  <= {mosi_q[0], spi_mosi};
            warm    <= {warm[0], 1'b1};
            cs_prev <= warm[1] ? cs_s : 1'b0;
        end
    end

    assign cs_s     = cs_q[1];
    assign sample   = sck_q[1] & ~sck_q[2] & ~cs_s;
    assign cs_fall  = cs_prev & ~cs_s;
    assign last_bit = (cnt == CW'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (cs_fall) state_nx = SHIFT;
            SHIFT:   if (cs_s) state_nx = IDLE;
                     else if (sample && last_bit) state_nx = PUSH;
            PUSH:    state_nx = cs_s ? IDLE : SHIFT;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        push     = (state == PUSH);
        shift_en = (state == SHIFT) && !cs_s && sample;
        cnt_clr  = ((state == IDLE) && cs_fall) || ((state == SHIFT) && cs_s);
        ferr_set = (state == SHIFT) && cs_s && (cnt != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else begin
            if (shift_en) shreg <= {shreg[W-2:0], mosi_q[1]};
            if (cnt_clr)       cnt <= '0;
            else if (shift_en) cnt <= last_bit ? '0 : cnt + CW'(1);
        end
    end

    // The head register looks past a word popped this edge, so a pop shows the
    // next entry one cycle later and never repeats the popped one.
    assign pop        = out_if.out_valid & out_if.out_ready;
    assign full       = (count == LW'(DEPTH));
    assign wr         = push & (~full | pop);
    assign drop       = push & full & ~pop;
    assign rptr_nx    = rptr + AW'(pop);
    assign count_left = count - LW'(pop);

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= shreg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr             <= '0;
            rptr             <= '0;
            count            <= '0;
            out_if.out_valid <= 1'b0;
            out_if.out_data  <= '0;
            overflow         <= 1'b0;
            frame_err        <= 1'b0;
        end else begin
            if (wr) wptr <= wptr + AW'(1);
            rptr             <= rptr_nx;
            count            <= count + LW'(wr) - LW'(pop);
            out_if.out_valid <= (count_left != '0);
            out_if.out_data  <= (count_left != '0) ? mem[rptr_nx] : '0;
            overflow         <= drop | (overflow & ~clear_err);
            frame_err        <= ferr_set | (frame_err & ~clear_err);
        end
    end

    assign level = count;
endmodule

// File: tb/tb_spi_trace_rx.sv
// Randomized and directed bench for spi_trace_rx against a queue-based reference model.
module tb_spi_trace_rx;
    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0, rst_n = 1'b1;
    logic spi_sck = 1'b0, spi_cs = 1'b1, spi_mosi = 1'b0, clear_err = 1'b0;
    logic overflow, frame_err;
    logic [$clog2(DEPTH):0] level;

    spi_trace_rx_if #(.W(W)) bus ();

    spi_trace_rx #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
        .out_if(bus), .overflow(overflow), .frame_err(frame_err),
        .clear_err(clear_err), .level(level)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {int at; bit is_push; logic [W-1:0] w;} ev_t;
    ev_t          sched[$];
    logic [W-1:0] mq[$];
    logic [W-1:0] got[$];
    bit           m_ovf = 0, m_ferr = 0, rnd_mode = 0;
    bit           m_pop, m_push, m_fe, m_drop;
    int           m_sz;
    logic [W-1:0] m_pw;
    int           first_valid_edge = -1;
    int           n_chk = 0, n_fail = 0;
    int           pa;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: FIFO as a queue, words enter at the edge the synchronizer latency dictates.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_data", bus.out_data, 0);
            chk("rst_level", level, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_frame_err", frame_err, 0);
            mq.delete(); sched.delete(); m_ovf = 0; m_ferr = 0;
        end else begin
            chk("level", level, mq.size());
            chk("overflow", overflow, m_ovf);
            chk("frame_err", frame_err, m_ferr);
            if (bus.out_valid) begin
                if (first_valid_edge < 0) first_valid_edge = edge_cnt;
                if (mq.size() == 0) chk("valid_with_empty_model", bus.out_valid, 0);
                else                chk("out_data", bus.out_data, mq[0]);
            end
            m_sz  = mq.size();
            m_pop = bus.out_valid && bus.out_ready;
            if (m_pop) begin
                got.push_back(bus.out_data);
                if (mq.size() > 0) void'(mq.pop_front());
            end
            m_push = 0; m_fe = 0; m_pw = '0;
            for (int i = sched.size() - 1; i >= 0; i--) begin
                if (sched[i].at == edge_cnt + 1) begin
                    if (sched[i].is_push) begin m_push = 1; m_pw = sched[i].w; end
                    else m_fe = 1;
                    sched.delete(i);
                end
            end
            m_drop = m_push && (m_sz == DEPTH) && !m_pop;
            if (m_push && !m_drop) mq.push_back(m_pw);
            if (clear_err) begin m_ovf = m_drop; m_ferr = m_fe; end
            else begin m_ovf = m_ovf | m_drop; m_ferr = m_ferr | m_fe; end
        end
    end

    always @(posedge clk) begin
        if (rnd_mode) begin
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
            clear_err     = ($urandom_range(0, 15) == 0);
        end
    end

    task automatic clk_wait(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1; clk_wait(1); clear_err = 1'b0;
    endtask

    // sck half period = 4 clk; a word's last rising edge after edge n lands in the FIFO at edge n+4.
    task automatic send(input logic [127:0] data, input int nbits, input bit raise,
                        input bit live, input bit rdy_trig, output int push_at);
        int n;
        logic [127:0] sh;
        push_at = -1;
        spi_cs = 1'b0;
        clk_wait(4);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = data[nbits-1-i];
            clk_wait(4);
            spi_sck = 1'b1;
            n = edge_cnt;
            if (live && ((i + 1) % W == 0)) begin
                sh = data >> (nbits - 1 - i);
                sched.push_back('{n + 4, 1'b1, sh[W-1:0]});
                push_at = n + 4;
            end
            for (int j = 0; j < 4; j++) begin
                @(posedge clk); #1;
                if (rdy_trig && i == nbits - 1 && edge_cnt == n + 3) bus.out_ready = 1'b1;
            end
            spi_sck = 1'b0;
        end
        if (raise) begin
            clk_wait(4);
            spi_cs = 1'b1;
            if (live && (nbits % W) != 0) sched.push_back('{edge_cnt + 3, 1'b0, '0});
            clk_wait(8);
        end
    endtask

    function automatic logic [63:0] got_at(input int i);
        return (i < got.size()) ? 64'(got[i]) : 64'hx;
    endfunction

    initial begin
        bus.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_level", level, 0);
        clk_wait(3);
        rst_n = 1'b1;
        clk_wait(4);

        // single frame, latency and pulse count
        bus.out_ready = 1'b1; got.delete(); first_valid_edge = -1;
        send(128'h8000_0004, 32, 1, 1, 0, pa);
        clk_wait(6);
        chk("t1_words", got.size(), 1);
        chk("t1_data", got_at(0), 64'h8000_0004);
        chk("t1_latency", first_valid_edge, pa + 1);
        chk("t1_flags", {overflow, frame_err}, 0);

        // overflow with consumer stalled
        bus.out_ready = 1'b0; got.delete();
        for (int k = 1; k <= 5; k++) send(128'(k), 32, 1, 1, 0, pa);
        clk_wait(6);
        chk("t2_level", level, 4);
        chk("t2_overflow", overflow, 1);
        bus.out_ready = 1'b1; clk_wait(10); bus.out_ready = 1'b0;
        chk("t2_words", got.size(), 4);
        for (int i = 0; i < 4; i++) chk("t2_data", got_at(i), 64'(i + 1));
        chk("t2_drained_valid", bus.out_valid, 0);
        pulse_clear();
        chk("t2_clear", overflow, 0);

        // push and pop together at full
        got.delete();
        for (int k = 1; k <= 4; k++) send(128'(k), 32, 1, 1, 0, pa);
        send(128'd5, 32, 1, 1, 1, pa);
        clk_wait(10);
        chk("t3_overflow", overflow, 0);
        chk("t3_words", got.size(), 5);
        for (int i = 0; i < 5; i++) chk("t3_order", got_at(i), 64'(i + 1));

        // aborted frame then a good one
        got.delete();
        send(128'h1_ABCD, 17, 1, 1, 0, pa);
        send(128'hDEAD_BEEF, 32, 1, 1, 0, pa);
        clk_wait(6);
        chk("t4_frame_err", frame_err, 1);
        chk("t4_words", got.size(), 1);
        chk("t4_data", got_at(0), 64'hDEAD_BEEF);
        pulse_clear();
        chk("t4_clear", frame_err, 0);

        // two-word frame
        got.delete();
        send(128'h1111_1111_2222_2222, 64, 1, 1, 0, pa);
        clk_wait(6);
        chk("t5_words", got.size(), 2);
        chk("t5_w0", got_at(0), 64'h1111_1111);
        chk("t5_w1", got_at(1), 64'h2222_2222);
        chk("t5_frame_err", frame_err, 0);

        // reset mid-frame; remainder of that frame must be ignored
        got.delete();
        send(128'h3FF, 10, 0, 1, 0, pa);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", bus.out_valid, 0);
        chk("t6_rst_flags", {overflow, frame_err}, 0);
        clk_wait(3);
        rst_n = 1'b1;
        send(128'h2A_5A5A, 22, 1, 0, 0, pa);
        send(128'hCAFE_F00D, 32, 1, 1, 0, pa);
        clk_wait(6);
        chk("t6_flags", {overflow, frame_err}, 0);
        chk("t6_words", got.size(), 1);
        chk("t6_data", got_at(0), 64'hCAFE_F00D);

        // random frames, random consumer, random clears
        rnd_mode = 1;
        repeat (25) begin
            int nb;
            nb = W * $urandom_range(1, 2) + (($urandom_range(0, 3) == 0) ? $urandom_range(1, W - 1) : 0);
            send({$urandom, $urandom, $urandom, $urandom}, nb, 1, 1, 0, pa);
        end
        rnd_mode = 0;
        clk_wait(2);
        bus.out_ready = 1'b1; clear_err = 1'b0;
        clk_wait(20);
        chk("rnd_drain_level", level, 0);
        chk("rnd_drain_valid", bus.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
